// File: rtl/dqs_lane_eye_centre_ctrl.sv
// ---------------------------------------------------------------------------
// dqs_lane_eye_centre_ctrl
//
// Multi-lane DQS read-eye centring controller. Lanes are trained one at a
// time. For each lane the delay line is loaded to tap 0. The controller then
// loops: clear the eye-monitor flags, wait for them to settle, and sample
// EARLY/LATE. A one-sided sample moves the tap by one step toward the eye
// centre. A neutral sample (both or neither flag) counts toward lock. The lane
// passes after LOCK_CNT consecutive neutral samples. It fails on saturation at
// 0/MAX_TAP, on the IOD out-of-range flag, or after ITER_MAX samples.
//
// Ports
//   FAB_CLK                  : clock, all logic on the rising edge
//   SYNC_RST                 : synchronous active-high reset
//   START                    : 1-cycle pulse, accepted only in IDLE/DONE
//   BUSY / DONE              : training in progress / all lanes finished
//   LANE_FAIL[NUM_LANES]     : per-lane failure, valid with DONE
//   TAP_VAL[NUM_LANES*TAP_W] : per-lane tap position, lane i at [i*TAP_W +: TAP_W]
//   EYE_MONITOR_EARLY/LATE   : per-lane eye-monitor flags from the IOD
//   DELAY_LINE_OUT_OF_RANGE  : per-lane IOD out-of-range flag
//   EYE_MONITOR_CLEAR_FLAGS  : 1-cycle pulse on the active lane
//   DELAY_LINE_LOAD          : 1-cycle pulse on the active lane (tap -> 0)
//   DELAY_LINE_MOVE          : 1-cycle pulse on the active lane (one tap step)
//   DELAY_LINE_DIRECTION     : 1 = increment, 0 = decrement; valid with MOVE
// ---------------------------------------------------------------------------
module dqs_lane_eye_centre_ctrl #(
  parameter int NUM_LANES  = 2,
  parameter int TAP_W      = 8,
  parameter int MAX_TAP    = 255,
  parameter int SETTLE_CYC = 8,
  parameter int LOCK_CNT   = 4,
  parameter int ITER_MAX   = 512
) (
  input  logic                       FAB_CLK,
  input  logic                       SYNC_RST,
  input  logic                       START,
  output logic                       BUSY,
  output logic                       DONE,
  output logic [NUM_LANES-1:0]       LANE_FAIL,
  output logic [NUM_LANES*TAP_W-1:0] TAP_VAL,
  input  logic [NUM_LANES-1:0]       EYE_MONITOR_EARLY,
  input  logic [NUM_LANES-1:0]       EYE_MONITOR_LATE,
  input  logic [NUM_LANES-1:0]       DELAY_LINE_OUT_OF_RANGE,
  output logic [NUM_LANES-1:0]       EYE_MONITOR_CLEAR_FLAGS,
  output logic [NUM_LANES-1:0]       DELAY_LINE_LOAD,
  output logic [NUM_LANES-1:0]       DELAY_LINE_MOVE,
  output logic [NUM_LANES-1:0]       DELAY_LINE_DIRECTION
);

  localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int ITER_W = $clog2(ITER_MAX + 1);
  localparam int WAIT_W = $clog2(SETTLE_CYC + 1);
  localparam int LOCK_W = $clog2(LOCK_CNT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CLEAR, S_WAIT, S_SAMPLE, S_STEP, S_NEXT, S_DONE
  } state_e;

  state_e               state_q;
  logic [LANE_W-1:0]    lane_q;
  logic [TAP_W-1:0]     tap_q [NUM_LANES];
  logic [ITER_W-1:0]    iter_q;
  logic [LOCK_W-1:0]    lock_q;
  logic [WAIT_W-1:0]    wait_q;
  logic                 busy_q;
  logic                 done_q;
  logic [NUM_LANES-1:0] fail_q;
  logic [NUM_LANES-1:0] clear_q;
  logic [NUM_LANES-1:0] load_q;
  logic [NUM_LANES-1:0] move_q;
  logic [NUM_LANES-1:0] dir_q;

  // Active-lane views and incremented counters used by the SAMPLE decision.
  logic [NUM_LANES-1:0] lane_oh;
  logic [TAP_W-1:0]     tap_cur;
  logic [ITER_W-1:0]    iter_d;
  logic [LOCK_W-1:0]    lock_d;
  logic                 is_late;
  logic                 is_early;
  logic                 oor_s;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    lane_oh         = '0;
    lane_oh[lane_q] = 1'b1;
  end

  assign tap_cur  = tap_q[lane_q];
  assign iter_d   = iter_q + ITER_W'(1);
  assign lock_d   = lock_q + LOCK_W'(1);
  assign is_late  = EYE_MONITOR_LATE[lane_q] & ~EYE_MONITOR_EARLY[lane_q];
  assign is_early = EYE_MONITOR_EARLY[lane_q] & ~EYE_MONITOR_LATE[lane_q];
  assign oor_s    = DELAY_LINE_OUT_OF_RANGE[lane_q];

  // NOTE: state is updated with non-blocking assignments only. Every read in
  // this block then sees the value from before the clock edge.
  always_ff @(posedge FAB_CLK) begin
    if (SYNC_RST) begin
      state_q <= S_IDLE;
      lane_q  <= '0;
      iter_q  <= '0;
      lock_q  <= '0;
      wait_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fail_q  <= '0;
      clear_q <= '0;
      load_q  <= '0;
      move_q  <= '0;
      dir_q   <= '0;
      // NOTE: the tap array drives TAP_VAL directly, so it must be reset like
      // any other register. It is flops, not a RAM.
      for (int i = 0; i < NUM_LANES; i++) tap_q[i] <= '0;
    end else begin
      // Strobes are single-cycle: low unless the next state raises them.
      clear_q <= '0;
      load_q  <= '0;
      move_q  <= '0;
      dir_q   <= '0;

      case (state_q)
        S_IDLE, S_DONE: begin
          if (START) begin
            state_q  <= S_LOAD;
            lane_q   <= '0;
            fail_q   <= '0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
            load_q   <= NUM_LANES'(1);
            tap_q[0] <= '0;
            iter_q   <= '0;
            lock_q   <= '0;
          end
        end

        S_LOAD, S_STEP: begin
          state_q <= S_CLEAR;
          clear_q <= lane_oh;
        end

        S_CLEAR: begin
          state_q <= S_WAIT;
          wait_q  <= '0;
        end

        S_WAIT: begin
          if (wait_q == WAIT_W'(SETTLE_CYC - 1)) state_q <= S_SAMPLE;
          else                                   wait_q  <= wait_q + WAIT_W'(1);
        end

        S_SAMPLE: begin
          iter_q <= iter_d;
          if (oor_s || iter_d == ITER_W'(ITER_MAX)) begin
            fail_q[lane_q] <= 1'b1;
            state_q        <= S_NEXT;
          end else if (is_late) begin
            lock_q <= '0;
            // Saturation is caught here, so no MOVE is ever issued past the end.
            if (tap_cur == TAP_W'(MAX_TAP)) begin
              fail_q[lane_q] <= 1'b1;
              state_q        <= S_NEXT;
            end else begin
              state_q        <= S_STEP;
              move_q         <= lane_oh;
              dir_q          <= lane_oh;
              tap_q[lane_q]  <= tap_cur + TAP_W'(1);
            end
          end else if (is_early) begin
            lock_q <= '0;
            if (tap_cur == '0) begin
              fail_q[lane_q] <= 1'b1;
              state_q        <= S_NEXT;
            end else begin
              state_q        <= S_STEP;
              move_q         <= lane_oh;
              tap_q[lane_q]  <= tap_cur - TAP_W'(1);
            end
          end else begin
            lock_q <= lock_d;
            if (lock_d == LOCK_W'(LOCK_CNT)) begin
              state_q <= S_NEXT;
            end else begin
              state_q <= S_CLEAR;
              clear_q <= lane_oh;
            end
          end
        end

        S_NEXT: begin
          if (lane_q == LANE_W'(NUM_LANES - 1)) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            state_q                     <= S_LOAD;
            lane_q                      <= lane_q + LANE_W'(1);
            load_q                      <= lane_oh << 1;
            tap_q[lane_q + LANE_W'(1)]  <= '0;
            iter_q                      <= '0;
            lock_q                      <= '0;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_tap
    assign TAP_VAL[g*TAP_W +: TAP_W] = tap_q[g];
  end

  assign BUSY                    = busy_q;
  assign DONE                    = done_q;
  assign LANE_FAIL               = fail_q;
  assign EYE_MONITOR_CLEAR_FLAGS = clear_q;
  assign DELAY_LINE_LOAD         = load_q;
  assign DELAY_LINE_MOVE         = move_q;
  assign DELAY_LINE_DIRECTION    = dir_q;

endmodule

// File: tb/tb_dqs_lane_eye_centre_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dqs_lane_eye_centre_ctrl
//
// Testbench for dqs_lane_eye_centre_ctrl with two lanes, MAX_TAP=7,
// SETTLE_CYC=3, LOCK_CNT=4 and ITER_MAX=16.
//
// A behavioural IOD model tracks each lane's tap from the LOAD/MOVE strobes.
// It drives EARLY/LATE/OUT_OF_RANGE according to a per-lane eye profile.
// Expected MOVE events and end-of-run results are queued before each START
// and compared as the DUT produces them.
// ---------------------------------------------------------------------------
module tb_dqs_lane_eye_centre_ctrl;

  localparam int NL     = 2;
  localparam int TW     = 8;
  localparam int MAXT   = 7;
  localparam int SETTLE = 3;
  localparam int LOCKN  = 4;
  localparam int ITERN  = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             busy, done;
  logic [NL-1:0]    lane_fail;
  logic [NL*TW-1:0] tap_val;
  logic [NL-1:0]    early, late, oor;
  logic [NL-1:0]    clear, load, move, dir;

  always #5 clk = ~clk;

  dqs_lane_eye_centre_ctrl #(
    .NUM_LANES(NL), .TAP_W(TW), .MAX_TAP(MAXT),
    .SETTLE_CYC(SETTLE), .LOCK_CNT(LOCKN), .ITER_MAX(ITERN)
  ) dut (
    .FAB_CLK                 (clk),
    .SYNC_RST                (rst),
    .START                   (start),
    .BUSY                    (busy),
    .DONE                    (done),
    .LANE_FAIL               (lane_fail),
    .TAP_VAL                 (tap_val),
    .EYE_MONITOR_EARLY       (early),
    .EYE_MONITOR_LATE        (late),
    .DELAY_LINE_OUT_OF_RANGE (oor),
    .EYE_MONITOR_CLEAR_FLAGS (clear),
    .DELAY_LINE_LOAD         (load),
    .DELAY_LINE_MOVE         (move),
    .DELAY_LINE_DIRECTION    (dir)
  );

  // Eye profiles presented by the IOD model on each lane.
  typedef enum {M_NEUTRAL, M_CENTRE5, M_OVERSHOOT, M_LATE, M_LATE_OOR2, M_OSC} mode_e;

  typedef struct { int lane; int dir; } mv_t;
  typedef struct { int tap0; int tap1; int fail; int clr0; int clr1; } res_t;

  mv_t   mv_q[$];
  res_t  res_q[$];

  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;
  int    strobe_cnt = 0;
  int    tap_m[NL];
  int    clr_cnt[NL];
  int    last_move[NL];
  bit    went_down[NL];
  mode_e mode[NL];
  bit    sb_en;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // IOD model: flags as a function of the model tap and the lane's profile.
  task automatic drive_flags();
    logic [NL-1:0] e, lt, o;
    e = '0; lt = '0; o = '0;
    for (int l = 0; l < NL; l++) begin
      case (mode[l])
        M_CENTRE5: begin
          lt[l] = (tap_m[l] < 5);
          if (tap_m[l] >= 5) begin e[l] = 1'b1; lt[l] = 1'b1; end
        end
        M_OVERSHOOT: begin
          if (!went_down[l]) begin
            if (tap_m[l] < 3) lt[l] = 1'b1;
            else              e[l]  = 1'b1;
          end
        end
        M_LATE:      lt[l] = 1'b1;
        M_LATE_OOR2: begin lt[l] = 1'b1; o[l] = (tap_m[l] == 2); end
        M_OSC: begin
          if (tap_m[l] == 0) lt[l] = 1'b1;
          else               e[l]  = 1'b1;
        end
        default: ;
      endcase
    end
    early = e; late = lt; oor = o;
  endtask

  // One clock: observe the DUT at the falling edge, score MOVEs, update the model.
  task automatic tick();
    mv_t m;
    @(negedge clk);
    cyc++;
    if (load  != '0) check("load_onehot",  32'($countones(load)),  1);
    if (clear != '0) check("clear_onehot", 32'($countones(clear)), 1);
    if (move  != '0) check("move_onehot",  32'($countones(move)),  1);
    if (dir   != '0) check("dir_only_with_move", 32'(dir & ~move), 0);
    if ((load | clear | move) != '0) strobe_cnt++;
    for (int l = 0; l < NL; l++) begin
      if (clear[l]) clr_cnt[l]++;
      if (load[l])  tap_m[l] = 0;
      if (move[l]) begin
        if (last_move[l] >= 0) check("move_gap", 32'(cyc - last_move[l]), SETTLE + 3);
        last_move[l] = cyc;
        if (sb_en) begin
          if (mv_q.size() == 0) begin
            check("move_unexpected", 32'(mv_q.size()), 1);
          end else begin
            m = mv_q.pop_front();
            check("move_lane", 32'(l), 32'(m.lane));
            check("move_dir",  32'(dir[l]), 32'(m.dir));
          end
        end
        tap_m[l] = tap_m[l] + (dir[l] ? 1 : -1);
        if (!dir[l]) went_down[l] = 1'b1;
      end
    end
    drive_flags();
  endtask

  task automatic pulse_start();
    for (int l = 0; l < NL; l++) last_move[l] = -1;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic push_move(input int lane, input int d);
    mv_t m;
    m.lane = lane; m.dir = d;
    mv_q.push_back(m);
  endtask

  // Start a full training run, optionally poke START while busy, then score results.
  task automatic run_test(input string name, input bit poke);
    int   c0, c1, n;
    res_t r;
    c0 = clr_cnt[0];
    c1 = clr_cnt[1];
    for (int l = 0; l < NL; l++) went_down[l] = 1'b0;
    drive_flags();
    pulse_start();
    check({name, ".load_lane0"}, 32'(load), 1);
    check({name, ".busy_on"},    32'(busy), 1);
    check({name, ".done_off"},   32'(done), 0);
    check({name, ".fail_clr"},   32'(lane_fail), 0);
    if (poke) begin
      repeat (10) tick();
      pulse_start();
      check({name, ".start_ignored_busy"}, 32'(busy), 1);
    end
    n = 0;
    while (!done && n < 3000) begin tick(); n++; end
    check({name, ".done_seen"}, 32'(done), 1);
    r = res_q.pop_front();
    check({name, ".busy_off"},  32'(busy), 0);
    check({name, ".tap0"},      32'(tap_val[TW-1:0]), 32'(r.tap0));
    check({name, ".tap1"},      32'(tap_val[2*TW-1:TW]), 32'(r.tap1));
    check({name, ".lane_fail"}, 32'(lane_fail), 32'(r.fail));
    check({name, ".clears0"},   32'(clr_cnt[0] - c0), 32'(r.clr0));
    check({name, ".clears1"},   32'(clr_cnt[1] - c1), 32'(r.clr1));
    check({name, ".moves_left"}, 32'(mv_q.size()), 0);
    mv_q.delete();
  endtask

  initial begin
    int n, s;
    rst = 1'b1; start = 1'b0; early = '0; late = '0; oor = '0; sb_en = 1'b1;
    for (int l = 0; l < NL; l++) begin
      tap_m[l] = 0; clr_cnt[l] = 0; last_move[l] = -1;
      went_down[l] = 1'b0; mode[l] = M_NEUTRAL;
    end
    repeat (3) tick();
    check("rst.busy",  32'(busy), 0);
    check("rst.done",  32'(done), 0);
    check("rst.fail",  32'(lane_fail), 0);
    check("rst.tap",   32'(tap_val), 0);
    check("rst.strb",  32'(load | clear | move), 0);
    check("rst.dir",   32'(dir), 0);
    rst = 1'b0;
    tick();

    // Lane 0 centres at tap 5; lane 1 is centred at tap 0.
    mode[0] = M_CENTRE5; mode[1] = M_NEUTRAL;
    repeat (5) push_move(0, 1);
    res_q.push_back('{5, 0, 0, 9, 4});
    run_test("t2_centre", 1'b0);

    // Lane 1 overshoots to tap 3, steps back once, then locks at tap 2.
    mode[0] = M_NEUTRAL; mode[1] = M_OVERSHOOT;
    repeat (3) push_move(1, 1);
    push_move(1, 0);
    res_q.push_back('{0, 2, 0, 4, 8});
    run_test("t3_early", 1'b1);

    // Lane 0 always LATE and saturates at MAX_TAP; lane 1 still trains.
    mode[0] = M_LATE; mode[1] = M_CENTRE5;
    repeat (7) push_move(0, 1);
    repeat (5) push_move(1, 1);
    res_q.push_back('{7, 5, 1, 8, 9});
    run_test("t4_sat", 1'b0);

    // Lane 1 reports out-of-range at tap 2; no further lane 1 MOVE.
    mode[0] = M_NEUTRAL; mode[1] = M_LATE_OOR2;
    repeat (2) push_move(1, 1);
    res_q.push_back('{0, 2, 2, 4, 3});
    run_test("t5_oor", 1'b0);

    // Lane 0 oscillates between taps 0 and 1 until the 16th sample times out.
    mode[0] = M_OSC; mode[1] = M_NEUTRAL;
    for (int i = 0; i < 15; i++) push_move(0, (i % 2 == 0) ? 1 : 0);
    res_q.push_back('{1, 0, 1, 16, 4});
    run_test("t6_timeout", 1'b0);

    // Restart from DONE: fail flags clear and lane 0 is reloaded.
    mode[0] = M_NEUTRAL; mode[1] = M_NEUTRAL;
    res_q.push_back('{0, 0, 0, 4, 4});
    run_test("t6_restart", 1'b0);

    // Reset in the middle of a WAIT period aborts training.
    mode[0] = M_LATE; mode[1] = M_NEUTRAL;
    sb_en = 1'b0;
    for (int l = 0; l < NL; l++) went_down[l] = 1'b0;
    drive_flags();
    pulse_start();
    n = 0;
    while (tap_m[0] != 2 && n < 500) begin tick(); n++; end
    check("t1.tap_before_rst", 32'(tap_val[TW-1:0]), 2);
    n = 0;
    while (!clear[0] && n < 100) begin tick(); n++; end
    check("t1.clear_seen", 32'(clear[0]), 1);
    tick();
    rst = 1'b1;
    tick();
    check("t1.busy",  32'(busy), 0);
    check("t1.done",  32'(done), 0);
    check("t1.tap",   32'(tap_val), 0);
    check("t1.fail",  32'(lane_fail), 0);
    check("t1.strb",  32'(load | clear | move), 0);
    check("t1.dir",   32'(dir), 0);
    rst = 1'b0;
    s = strobe_cnt;
    repeat (30) tick();
    check("t1.no_strobes_after", 32'(strobe_cnt - s), 0);
    check("t1.idle_busy", 32'(busy), 0);
    check("t1.idle_done", 32'(done), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
